eq_req_issuer: RTL and testbench

//  Requester-side endpoint of the EQ request/response interface, one instance per core (ReqTransCore, ReqRecvCore, RespRecvCore).

---
 rtl/eq_req_issuer.sv | 143 ++++++++++++++
 tb/tb_eq_req_issuer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_req_issuer.sv
// Requester-side EQ endpoint: packs one core event into a request head,
// issues it, waits for the response (or a timeout) and returns it to the core.
module eq_req_issuer #(
    parameter int EQ_REQ_HEAD_WIDTH  = 64,
    parameter int EQ_RESP_HEAD_WIDTH = 128,
    parameter int EQN_W              = 8,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic [EQN_W-1:0]              ev_eqn,
    input  logic [7:0]                    ev_type,
    input  logic [31:0]                   ev_param,
    output logic                          eq_req_valid,
    output logic [EQ_REQ_HEAD_WIDTH-1:0]  eq_req_head,
    input  logic                          eq_req_ready,
    input  logic                          eq_resp_valid,
    input  logic [EQ_RESP_HEAD_WIDTH-1:0] eq_resp_head,
    output logic                          eq_resp_ready,
    output logic                          done_valid,
    output logic [EQ_RESP_HEAD_WIDTH-1:0] done_head,
    output logic                          done_timeout,
    input  logic                          done_ready,
    output logic [31:0]                   stat_req_cnt,
    output logic [15:0]                   stat_timeout_cnt,
    output logic [15:0]                   stat_stray_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    localparam bit        TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                          state_q, state_d;
    logic [EQ_REQ_HEAD_WIDTH-1:0]    req_head_q, req_head_d;
    logic [EQ_RESP_HEAD_WIDTH-1:0]   done_head_q, done_head_d;
    logic                            done_tmo_q, done_tmo_d;
    logic [15:0]                     timer_q, timer_d;
    logic [31:0]                     req_cnt_q, req_cnt_d;
    logic [15:0]                     tmo_cnt_q, tmo_cnt_d;
    logic [15:0]                     stray_cnt_q, stray_cnt_d;
    logic                            rdy_q;
    logic                            resp_fire;

    // rdy_q keeps every handshake closed while reset is applied
    assign resp_fire     = eq_resp_valid & rdy_q;
    assign ev_ready      = (state_q == IDLE) & rdy_q;
    assign eq_req_valid  = (state_q == REQ);
    assign done_valid    = (state_q == DONE);
    assign eq_req_head   = req_head_q;
    assign eq_resp_ready = rdy_q;
    assign done_head     = done_head_q;
    assign done_timeout  = done_tmo_q;
    assign stat_req_cnt  = req_cnt_q;
    assign stat_timeout_cnt = tmo_cnt_q;
    assign stat_stray_cnt   = stray_cnt_q;

    always_comb begin
        state_d     = state_q;
        req_head_d  = req_head_q;
        done_head_d = done_head_q;
        done_tmo_d  = done_tmo_q;
        timer_d     = timer_q;
        req_cnt_d   = req_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stray_cnt_d = stray_cnt_q;

        if (resp_fire && state_q != WAIT && stray_cnt_q != 16'hFFFF) begin
            stray_cnt_d = stray_cnt_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (ev_valid && rdy_q) begin
                    req_head_d = EQ_REQ_HEAD_WIDTH'({ev_param, ev_type, ev_eqn});
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (eq_req_ready) begin
                    req_cnt_d = req_cnt_q + 32'd1;
                    timer_d   = 16'd0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // a response on the terminal count still wins over the timeout
                if (resp_fire) begin
                    done_head_d = eq_resp_head;
                    done_tmo_d  = 1'b0;
                    state_d     = DONE;
                end else if (TMO_EN && timer_q == TMO_LAST) begin
                    done_head_d = '0;
                    done_tmo_d  = 1'b1;
                    if (tmo_cnt_q != 16'hFFFF) begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_head_q  <= '0;
            done_head_q <= '0;
            done_tmo_q  <= 1'b0;
            timer_q     <= '0;
            req_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stray_cnt_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_head_q  <= req_head_d;
            done_head_q <= done_head_d;
            done_tmo_q  <= done_tmo_d;
            timer_q     <= timer_d;
            req_cnt_q   <= req_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stray_cnt_q <= stray_cnt_d;
            rdy_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eq_req_issuer.sv
// Randomized scoreboard bench for eq_req_issuer: a driver pushes expected
// request heads and results, a negedge monitor pops them on each handshake.
module tb_eq_req_issuer;

    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ev_valid = 1'b0;
    logic         ev_ready;
    logic [7:0]   ev_eqn = '0;
    logic [7:0]   ev_type = '0;
    logic [31:0]  ev_param = '0;
    logic         eq_req_valid;
    logic [63:0]  eq_req_head;
    logic         eq_req_ready = 1'b0;
    logic         eq_resp_valid = 1'b0;
    logic [127:0] eq_resp_head = '0;
    logic         eq_resp_ready;
    logic         done_valid;
    logic [127:0] done_head;
    logic         done_timeout;
    logic         done_ready = 1'b0;
    logic [31:0]  stat_req_cnt;
    logic [15:0]  stat_timeout_cnt;
    logic [15:0]  stat_stray_cnt;

    eq_req_issuer #(
        .EQ_REQ_HEAD_WIDTH (64),
        .EQ_RESP_HEAD_WIDTH(128),
        .EQN_W             (8),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_eqn          (ev_eqn),
        .ev_type         (ev_type),
        .ev_param        (ev_param),
        .eq_req_valid    (eq_req_valid),
        .eq_req_head     (eq_req_head),
        .eq_req_ready    (eq_req_ready),
        .eq_resp_valid   (eq_resp_valid),
        .eq_resp_head    (eq_resp_head),
        .eq_resp_ready   (eq_resp_ready),
        .done_valid      (done_valid),
        .done_head       (done_head),
        .done_timeout    (done_timeout),
        .done_ready      (done_ready),
        .stat_req_cnt    (stat_req_cnt),
        .stat_timeout_cnt(stat_timeout_cnt),
        .stat_stray_cnt  (stat_stray_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [63:0]  req_q[$];
    logic [128:0] done_q[$];

    int unsigned m_req = 0;
    int          m_tmo = 0;
    int          m_stray = 0;

    task automatic chk(string nm, logic [128:0] got, logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic fail_now(string nm);
        checks++;
        errs++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [63:0] pack(logic [7:0] e, logic [7:0] t,
                                         logic [31:0] p);
        return 64'(p) * 64'd65536 + 64'(t) * 64'd256 + 64'(e);
    endfunction

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(string tag);
        chk({tag, "_req_cnt"}, 129'(stat_req_cnt), 129'(m_req));
        chk({tag, "_tmo_cnt"}, 129'(stat_timeout_cnt), 129'(m_tmo));
        chk({tag, "_stray_cnt"}, 129'(stat_stray_cnt), 129'(m_stray));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (eq_req_valid && eq_req_ready) begin
                if (req_q.size() == 0) fail_now("req_unexpected");
                else chk("req_head", 129'(eq_req_head), 129'(req_q.pop_front()));
            end
            if (done_valid && done_ready) begin
                if (done_q.size() == 0) fail_now("done_unexpected");
                else chk("done_result", {done_timeout, done_head}, done_q.pop_front());
            end
        end
    end

    // One full transaction; k is the WAIT cycle index of the response
    task automatic txn(logic [7:0] e, logic [7:0] t, logic [31:0] p,
                       int rstall, int k, logic [127:0] rh, int dstall,
                       bit stray_in_req);
        int n;
        logic [63:0]  exp_head;
        logic [128:0] exp_done;
        exp_head = pack(e, t, p);
        ev_eqn = e;
        ev_type = t;
        ev_param = p;
        ev_valid = 1'b1;
        n = 0;
        while (!ev_ready && n < 50) begin
            step();
            n++;
        end
        if (!ev_ready) begin
            fail_now("ev_ready_wait");
            ev_valid = 1'b0;
            return;
        end
        req_q.push_back(exp_head);
        step();
        ev_valid = 1'b0;
        chk("ev_ready_busy", 129'(ev_ready), 129'(0));
        chk("req_valid_lat1", 129'(eq_req_valid), 129'(1));
        for (int i = 0; i < rstall; i++) begin
            if (stray_in_req && i == 0) begin
                eq_resp_valid = 1'b1;
                eq_resp_head = {$urandom, $urandom, $urandom, $urandom};
                m_stray = sat16(m_stray + 1);
            end
            step();
            eq_resp_valid = 1'b0;
            chk("req_hold_valid", 129'(eq_req_valid), 129'(1));
            chk("req_hold_head", 129'(eq_req_head), 129'(exp_head));
            chk("req_hold_evrdy", 129'(ev_ready), 129'(0));
            chk("req_hold_cnt", 129'(stat_req_cnt), 129'(m_req));
        end
        eq_req_ready = 1'b1;
        step();
        eq_req_ready = 1'b0;
        m_req++;
        if (k < T) begin
            exp_done = {1'b0, rh};
            repeat (k) step();
            chk("wait_no_done", 129'(done_valid), 129'(0));
            eq_resp_valid = 1'b1;
            eq_resp_head = rh;
            done_q.push_back(exp_done);
            step();
            eq_resp_valid = 1'b0;
        end else begin
            exp_done = {1'b1, 128'd0};
            done_q.push_back(exp_done);
            repeat (T - 1) step();
            chk("tmo_not_early", 129'(done_valid), 129'(0));
            step();
            chk("tmo_exact", 129'(done_valid), 129'(1));
            m_tmo = sat16(m_tmo + 1);
            repeat (k - T) step();
            eq_resp_valid = 1'b1;
            eq_resp_head = rh;
            m_stray = sat16(m_stray + 1);
            step();
            eq_resp_valid = 1'b0;
        end
        for (int i = 0; i < dstall; i++) begin
            chk("done_stall_valid", 129'(done_valid), 129'(1));
            chk("done_stall_data", {done_timeout, done_head}, exp_done);
            step();
        end
        done_ready = 1'b1;
        n = 0;
        while (!done_valid && n < 50) begin
            step();
            n++;
        end
        if (!done_valid) fail_now("done_wait");
        step();
        done_ready = 1'b0;
        chk("ev_ready_back", 129'(ev_ready), 129'(1));
        chk_stats("txn");
    endtask

    initial begin
        #1;
        chk("rst_ev_ready", 129'(ev_ready), 129'(0));
        chk("rst_req_valid", 129'(eq_req_valid), 129'(0));
        chk("rst_resp_ready", 129'(eq_resp_ready), 129'(0));
        chk("rst_done_valid", 129'(done_valid), 129'(0));
        chk("rst_req_head", 129'(eq_req_head), 129'(0));
        chk_stats("rst");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("resp_ready_up", 129'(eq_resp_ready), 129'(1));

        txn(8'd5, 8'h21, 32'h1234, 0, 3, 128'hABCD, 0, 0);
        txn(8'h3C, 8'h7E, 32'hDEAD_BEEF, 10, 2, 128'h55, 1, 1);
        txn(8'h01, 8'h02, 32'h0000_0003, 1, T + 2, 128'h99, 2, 0);
        txn(8'hFF, 8'hFF, 32'hFFFF_FFFF, 0, T - 1, 128'h1234_5678, 0, 0);

        for (int i = 0; i < 25; i++) begin
            txn(8'($urandom), 8'($urandom), $urandom,
                $urandom_range(0, 4), $urandom_range(0, T + 3),
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3), 1'($urandom));
        end

        eq_resp_valid = 1'b1;
        eq_resp_head = 128'hF00D;
        repeat (65540) step();
        eq_resp_valid = 1'b0;
        m_stray = sat16(m_stray + 65540);
        chk("stray_sat", 129'(stat_stray_cnt), 129'(m_stray));
        chk("stray_idle_ev_ready", 129'(ev_ready), 129'(1));
        chk("stray_idle_req_valid", 129'(eq_req_valid), 129'(0));
        chk("stray_idle_done_valid", 129'(done_valid), 129'(0));

        txn(8'h11, 8'h22, 32'h3344_5566, 0, 4, 128'hCAFE, 5, 0);

        ev_eqn = 8'h42;
        ev_type = 8'h10;
        ev_param = 32'h0BAD;
        ev_valid = 1'b1;
        req_q.push_back(pack(8'h42, 8'h10, 32'h0BAD));
        step();
        ev_valid = 1'b0;
        eq_req_ready = 1'b1;
        step();
        eq_req_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        m_req = 0;
        m_tmo = 0;
        m_stray = 0;
        chk("mid_rst_ev_ready", 129'(ev_ready), 129'(0));
        chk("mid_rst_req_valid", 129'(eq_req_valid), 129'(0));
        chk("mid_rst_req_head", 129'(eq_req_head), 129'(0));
        chk("mid_rst_resp_ready", 129'(eq_resp_ready), 129'(0));
        chk("mid_rst_done_valid", 129'(done_valid), 129'(0));
        chk("mid_rst_done_head", 129'(done_head), 129'(0));
        chk("mid_rst_done_tmo", 129'(done_timeout), 129'(0));
        chk_stats("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ev_ready", 129'(ev_ready), 129'(1));
        chk("post_rst_resp_ready", 129'(eq_resp_ready), 129'(1));
        chk("post_rst_done_valid", 129'(done_valid), 129'(0));

        txn(8'h07, 8'h08, 32'h0909, 2, 1, 128'hBEEF, 0, 0);

        repeat (3) step();
        chk("req_q_empty", 129'(req_q.size()), 129'(0));
        chk("done_q_empty", 129'(done_q.size()), 129'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
